// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: start/done sequencer that latches operands, launches a multi-cycle ALU and waits for done with a timeout
module alu_ctrl_seq #(
    parameter int WIDTH      = 8,
    parameter int OP_W       = 2,
    parameter int TIMEOUT    = 16,
    parameter bit DONE_PULSE = 1'b0
) (
    input  logic             clk,
    input  logic             reset_a_n,
    input  logic             start,
    input  logic [OP_W-1:0]  op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             done_in,
    input  logic [WIDTH-1:0] result_in,
    output logic             alu_go,
    output logic [OP_W-1:0]  op_out,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] result_out,
    output logic             done_out,
    output logic             busy,
    output logic             timeout_err,
    output logic [2:0]       state_out
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        CALC   = 3'd2,
        FIN    = 3'd3,
        ERR    = 3'd4
    } state_t;
    state_t state, state_d;
    logic start_q, armed, launch;
    logic [TW-1:0] timer;
    // armed blocks a start that was already high when reset released
    assign launch = start & ~start_q & armed;
    always_ff @(posedge clk or negedge reset_a_n) begin
        if (!reset_a_n) state <= IDLE;
        else state <= state_d;
    end
    always_comb begin
        state_d = IDLE;
        case (state)
            IDLE:    state_d = launch ? LAUNCH : IDLE;
            LAUNCH:  state_d = CALC;
            CALC:    state_d = done_in ? FIN : (timer == TMAX) ? ERR : CALC;
            FIN:     state_d = (DONE_PULSE || !start) ? IDLE : FIN;
            ERR:     state_d = start ? ERR : IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_a_n) begin
        if (!reset_a_n) begin
            start_q    <= 1'b0;
            armed      <= 1'b0;
            timer      <= '0;
            op_out     <= '0;
            a_out      <= '0;
            b_out      <= '0;
            result_out <= '0;
        end else begin
            start_q <= start;
            armed   <= armed | ~start;
            if (state == IDLE && launch) begin
                op_out <= op_in;
                a_out  <= a_in;
                b_out  <= b_in;
            end
            if (state == LAUNCH) timer <= '0;
            else if (state == CALC && !done_in && timer != TMAX) timer <= timer + 1'b1;
            if (state == CALC && done_in) result_out <= result_in;
        end
    end
    assign alu_go      = state == LAUNCH;
    assign busy        = state == LAUNCH || state == CALC;
    assign done_out    = state == FIN;
    assign timeout_err = state == ERR;
    assign state_out   = state;
endmodule
